// File: rtl/div_ctrl_if.sv
// Handshake/configuration bundle for div_ctrl: run control, config request and divider outputs.
interface div_ctrl_if #(
    parameter int unsigned W = 8
);
    logic         enable;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_div;
    logic [W-1:0] cfg_duty;
    logic         clk_div;
    logic         period_start;
    logic         cfg_err;
    logic         busy;

    modport master (
        output enable,
        output cfg_valid,
        output cfg_div,
        output cfg_duty,
        input  cfg_ready,
        input  clk_div,
        input  period_start,
        input  cfg_err,
        input  busy
    );

    modport slave (
        input  enable,
        input  cfg_valid,
        input  cfg_div,
        input  cfg_duty,
        output cfg_ready,
        output clk_div,
        output period_start,
        output cfg_err,
        output busy
    );
endinterface

// File: rtl/div_ctrl.sv
// Programmable clock divider with duty control; new ratios taken while running are
// held pending and applied only at a period boundary so no period is ever shortened.
module div_ctrl #(
    parameter int unsigned W        = 8,
    parameter int unsigned DIV_DEF  = 16,
    parameter int unsigned DUTY_DEF = 4
) (
    input logic       clk,
    input logic       rst_n,
    div_ctrl_if.slave io_bus
);
    typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

    state_e       r_state;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_div_act;
    logic [W-1:0] r_duty_act;
    logic [W-1:0] r_div_p;
    logic [W-1:0] r_duty_p;
    logic         r_clk_div;
    logic         r_period_start;
    logic         r_cfg_err;

    logic         w_ready;
    logic         w_accept;
    logic         w_bad;
    logic         w_load;
    logic         w_last;
    logic [W-1:0] w_duty_sat;

    assign w_ready    = (r_state != StPend);
    assign w_accept   = io_bus.cfg_valid && w_ready;
    assign w_bad      = (io_bus.cfg_div < W'(2));
    assign w_load     = w_accept && !w_bad;
    assign w_duty_sat = (io_bus.cfg_duty > io_bus.cfg_div) ? io_bus.cfg_div : io_bus.cfg_duty;
    assign w_last     = (r_cnt == (r_div_act - W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StIdle;
            r_cnt          <= '0;
            r_div_act      <= W'(DIV_DEF);
            r_duty_act     <= W'(DUTY_DEF);
            r_div_p        <= '0;
            r_duty_p       <= '0;
            r_clk_div      <= 1'b0;
            r_period_start <= 1'b0;
            r_cfg_err      <= 1'b0;
        end else begin
            r_cfg_err <= w_accept && w_bad;
            unique case (r_state)
                StIdle: begin
                    r_cnt          <= '0;
                    r_clk_div      <= 1'b0;
                    r_period_start <= 1'b0;
                    if (w_load) begin
                        r_div_act  <= io_bus.cfg_div;
                        r_duty_act <= w_duty_sat;
                    end
                    if (io_bus.enable) begin
                        r_state <= StRun;
                    end
                end
                StRun, StPend: begin
                    if (!io_bus.enable) begin
                        r_state        <= StIdle;
                        r_cnt          <= '0;
                        r_clk_div      <= 1'b0;
                        r_period_start <= 1'b0;
                        // Stopping counts as a boundary: pending (or same-edge) config lands now.
                        if (r_state == StPend) begin
                            r_div_act  <= r_div_p;
                            r_duty_act <= r_duty_p;
                        end else if (w_load) begin
                            r_div_act  <= io_bus.cfg_div;
                            r_duty_act <= w_duty_sat;
                        end
                    end else begin
                        r_clk_div      <= (r_cnt < r_duty_act);
                        r_period_start <= (r_cnt == '0);
                        r_cnt          <= w_last ? '0 : (r_cnt + W'(1));
                        if (w_load) begin
                            // Even on a wrap edge the request waits for the following wrap.
                            r_div_p  <= io_bus.cfg_div;
                            r_duty_p <= w_duty_sat;
                            r_state  <= StPend;
                        end else if ((r_state == StPend) && w_last) begin
                            r_div_act  <= r_div_p;
                            r_duty_act <= r_duty_p;
                            r_state    <= StRun;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.cfg_ready    = w_ready;
    assign io_bus.busy         = (r_state != StIdle);
    assign io_bus.clk_div      = r_clk_div;
    assign io_bus.period_start = r_period_start;
    assign io_bus.cfg_err      = r_cfg_err;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: vector table for IDLE config/reject cases, plus sequences for
// default pattern, pending reconfiguration, saturation, stop and asynchronous reset.
module tb_div_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    div_ctrl_if #(.W(8)) bus ();

    div_ctrl #(
        .W       (8),
        .DIV_DEF (16),
        .DUTY_DEF(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] div;
        logic [7:0] duty;
        logic       en;
        logic       e_clk;
        logic       e_ps;
        logic       e_err;
        logic       e_ready;
        logic       e_busy;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic v, input logic [7:0] d, input logic [7:0] u);
        bus.cfg_valid = v;
        bus.cfg_div   = d;
        bus.cfg_duty  = u;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        set_cfg(1'b0, 8'd0, 8'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.enable = 1'b0;
        set_cfg(1'b0, 8'd0, 8'd0);
        //           valid  div    duty   en     clk    ps     err    ready  busy
        vecs[0]  = '{1'b1, 8'd5, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 8'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 8'd0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset state
        step();
        check("rst clk_div", 32'(bus.clk_div), 0);
        check("rst period_start", 32'(bus.period_start), 0);
        check("rst cfg_err", 32'(bus.cfg_err), 0);
        check("rst busy", 32'(bus.busy), 0);
        check("rst div_act", 32'(dut.r_div_act), 16);
        check("rst duty_act", 32'(dut.r_duty_act), 4);
        rst_n = 1'b1;
        check("cfg_ready after release", 32'(bus.cfg_ready), 1);

        // IDLE load 5/2, run, rejected div=1 and div=0 requests
        for (int i = 0; i < 18; i++) begin
            set_cfg(vecs[i].valid, vecs[i].div, vecs[i].duty);
            bus.enable = vecs[i].en;
            step();
            check($sformatf("vec%0d clk_div", i), 32'(bus.clk_div), 32'(vecs[i].e_clk));
            check($sformatf("vec%0d period_start", i), 32'(bus.period_start),
                  32'(vecs[i].e_ps));
            check($sformatf("vec%0d cfg_err", i), 32'(bus.cfg_err), 32'(vecs[i].e_err));
            check($sformatf("vec%0d cfg_ready", i), 32'(bus.cfg_ready), 32'(vecs[i].e_ready));
            check($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
        end
        check("reject keeps div_act", 32'(dut.r_div_act), 5);
        check("reject keeps duty_act", 32'(dut.r_duty_act), 2);

        // Default 16/4 for two periods, then 8/8 requested at cnt 7 of the second period
        do_reset();
        bus.enable = 1'b1;
        step();
        check("entry busy", 32'(bus.busy), 1);
        check("entry clk_div", 32'(bus.clk_div), 0);
        for (int k = 0; k < 70; k++) begin
            logic e_clk;
            logic e_ps;
            logic e_rdy;
            if (k == 23) set_cfg(1'b1, 8'd8, 8'd8);
            else if (k == 48) set_cfg(1'b1, 8'd6, 8'd9);
            else set_cfg(1'b0, 8'd0, 8'd0);
            step();
            if (k < 32) begin
                e_clk = ((k % 16) < 4);
                e_ps  = ((k % 16) == 0);
            end else if (k < 56) begin
                e_clk = 1'b1;
                e_ps  = (((k - 32) % 8) == 0);
            end else begin
                e_clk = 1'b1;
                e_ps  = (((k - 56) % 6) == 0);
            end
            e_rdy = !((k >= 23 && k <= 30) || (k >= 48 && k <= 54));
            check($sformatf("k%0d clk_div", k), 32'(bus.clk_div), 32'(e_clk));
            check($sformatf("k%0d period_start", k), 32'(bus.period_start), 32'(e_ps));
            check($sformatf("k%0d cfg_ready", k), 32'(bus.cfg_ready), 32'(e_rdy));
        end
        check("saturated duty_act", 32'(dut.r_duty_act), 6);
        check("applied div_act", 32'(dut.r_div_act), 6);

        // Stop mid-period, then restart from cnt 0
        bus.enable = 1'b0;
        step();
        check("stop clk_div", 32'(bus.clk_div), 0);
        check("stop period_start", 32'(bus.period_start), 0);
        check("stop busy", 32'(bus.busy), 0);
        check("stop cnt", 32'(dut.r_cnt), 0);
        bus.enable = 1'b1;
        step();
        step();
        check("restart clk_div", 32'(bus.clk_div), 1);
        check("restart period_start", 32'(bus.period_start), 1);

        // Asynchronous reset while PEND discards the pending config
        set_cfg(1'b1, 8'd5, 8'd2);
        step();
        set_cfg(1'b0, 8'd0, 8'd0);
        check("pend cfg_ready", 32'(bus.cfg_ready), 0);
        check("pend clk_div", 32'(bus.clk_div), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async clk_div", 32'(bus.clk_div), 0);
        check("async period_start", 32'(bus.period_start), 0);
        check("async busy", 32'(bus.busy), 0);
        check("async cfg_ready", 32'(bus.cfg_ready), 1);
        check("async div_act", 32'(dut.r_div_act), 16);
        check("async duty_act", 32'(dut.r_duty_act), 4);
        bus.enable = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post-reset idle busy", 32'(bus.busy), 0);
        bus.enable = 1'b1;
        step();
        for (int k = 0; k < 32; k++) begin
            step();
            check($sformatf("r%0d clk_div", k), 32'(bus.clk_div), 32'((k % 16) < 4));
            check($sformatf("r%0d period_start", k), 32'(bus.period_start),
                  32'((k % 16) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter W, default 8: width of divide-ratio and duty fields.
REQ-002 SHALL have parameter DIV_DEF, default 16: divide ratio loaded at reset.
REQ-003 SHALL have parameter DUTY_DEF, default 4: high-cycle count loaded at reset.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1: 1 = run divider, 0 = stop.
REQ-007 SHALL have port cfg_valid, input, 1: configuration request.
REQ-008 SHALL have port cfg_ready, output, 1: request accepted on the edge where cfg_valid and cfg_ready are both 1.
REQ-009 SHALL have port cfg_div, input, W: requested divide ratio.
REQ-010 SHALL have port cfg_duty, input, W: requested high cycles per period.
REQ-011 SHALL have port clk_div, output, 1: divided clock, registered.
REQ-012 SHALL have port period_start, output, 1: one-cycle pulse marking counter value 0 in RUN.
REQ-013 SHALL have port cfg_err, output, 1: one-cycle pulse on a rejected request.
REQ-014 SHALL have port busy, output, 1: 1 while state is RUN or PEND.

Function
REQ-015 SHALL implement states IDLE, RUN, PEND; PEND = running with an accepted config not yet applied.
REQ-016 SHALL hold active ratio div_act, active duty duty_act, pending pair div_p/duty_p, and a W-bit counter cnt.
REQ-017 SHALL drive cfg_ready = 1 in IDLE and RUN, 0 in PEND.
REQ-018 SHALL reject an accepted request with cfg_div < 2: assert cfg_err for one cycle; no state or config change.
REQ-019 SHALL saturate a valid request's duty to cfg_div when cfg_duty > cfg_div; duty 0 gives constant-low output, duty = div gives constant-high output.
REQ-020 In IDLE, SHALL load a valid request directly into div_act/duty_act on the accepting edge.
REQ-021 In RUN, SHALL store a valid request in div_p/duty_p and go to PEND; this applies even when the accepting edge is also a wrap edge, so application occurs at the next wrap.
REQ-022 In RUN/PEND, on each edge: cnt <= 0 if cnt == div_act-1, else cnt+1; clk_div <= (cnt < duty_act); period_start <= (cnt == 0).
REQ-023 At wrap (cnt == div_act-1) in PEND, SHALL copy div_p/duty_p into div_act/duty_act, set cnt <= 0 and go to RUN; the new period uses the new values; no shortened or merged period.
REQ-024 IDLE -> RUN when enable = 1, with cnt = 0; the first clk_div rises one cycle after entry when duty_act > 0.
REQ-025 enable = 0 in RUN/PEND SHALL go to IDLE on the next edge with cnt <= 0, clk_div <= 0, period_start <= 0; pending config, if any, is applied to div_act/duty_act on that edge.
REQ-026 cnt arithmetic SHALL be W bits, never exceeding div_act-1; maximum ratio 2^W-1.

Reset
REQ-027 rst_n = 0 SHALL immediately set state IDLE, cnt 0, div_act DIV_DEF, duty_act DUTY_DEF, div_p/duty_p 0, clk_div 0, period_start 0, cfg_err 0, busy 0.
REQ-028 Reset asserted mid-period or in PEND SHALL discard any pending config; after release, the block waits in IDLE for enable.
REQ-029 cfg_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-030 Bench: reset, enable = 1, defaults -> clk_div pattern 4 high, 12 low, period 16; period_start every 16 cycles.
REQ-031 Bench: in IDLE, request div = 5, duty = 2, then enable -> 2 high, 3 low repeating; busy = 1.
REQ-032 Bench: in RUN (16/4) at cnt = 7, request 8/8 -> cfg_ready drops; current 16-cycle period completes; next period is constant high with period_start every 8 cycles.
REQ-033 Bench: request div = 1 or div = 0 -> single cfg_err pulse; div_act and duty_act are unchanged.
REQ-034 Bench: request div = 6, duty = 9 -> duty saturates to 6 and clk_div is constant high; deassert enable mid-period -> clk_div = 0 and cnt = 0 on the next edge.
REQ-035 Bench: assert rst_n low in PEND -> outputs reach reset values without a clock edge; after release and enable, the default 16/4 pattern resumes.
